// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: captures one parallel FFT result frame into a two-entry
// ping-pong buffer and streams it out one complex sample per cycle over valid/ready.
// Build option FFT_SER_BITREV_EN: read each frame in bit-reversed array order so a
// frame arriving in bit-reversed bin order leaves in natural order.

package fft_pkg;
    typedef struct packed {
        logic signed [15:0] r;
        logic signed [15:0] i;
    } complex_product_t;
endpackage

module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  complex_product_t [N-1:0] fft_in,
    input  logic                     in_valid,
    input  logic                     in_mode,
    output complex_product_t         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     out_mode,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [IDX_W-1:0]         cnt;
    logic [IDX_W-1:0]         cnt_next;
    logic [IDX_W-1:0]         sel;
    logic                     rp;
    logic                     rp_next;
    logic                     wp;
    logic [1:0]               full;
    logic                     release_buf;
    logic                     capture;
    logic                     drop;
    complex_product_t [N-1:0] frame_mem [2];
    logic                     mode_mem  [2];

    // A new frame is only accepted into a free write slot; otherwise it is lost.
    assign capture = in_valid && !full[wp];
    assign drop    = in_valid &&  full[wp];

`ifdef FFT_SER_BITREV_EN
    function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] rv;
        rv = '0;
        for (int b = 0; b < IDX_W; b++) begin
            rv[b] = v[IDX_W-1-b];
        end
        return rv;
    endfunction

    assign sel = bit_reverse(cnt);
`else
    assign sel = cnt;
`endif

    // Read FSM state, sample counter and read pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rp    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rp    <= rp_next;
        end
    end

    // Next-state logic: a full read buffer is presented at once, even from IDLE,
    // so a captured frame shows sample 0 in the cycle right after capture.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rp_next     = rp;
        release_buf = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rp]) begin
                    out_valid  = 1'b1;
                    state_next = DRAIN;
                    cnt_next   = out_ready ? IDX_W'(1) : '0;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt == LAST) begin
                        cnt_next    = '0;
                        release_buf = 1'b1;
                        rp_next     = ~rp;
                        state_next  = full[~rp] ? DRAIN : IDLE;
                    end else begin
                        cnt_next = cnt + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer occupancy, write pointer and sticky overflow; a drop beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= 2'b00;
            wp       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (release_buf) begin
                full[rp] <= 1'b0;
            end
            if (capture) begin
                full[wp] <= 1'b1;
                wp       <= ~wp;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame payload storage; contents only matter while the FULL flag is set.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_mem[wp] <= fft_in;
            mode_mem[wp]  <= in_mode;
        end
    end

    assign out_data  = out_valid ? frame_mem[rp][sel] : '0;
    assign out_mode  = out_valid ? mode_mem[rp] : 1'b0;
    assign out_index = cnt;
    assign out_last  = (cnt == LAST);

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb_fft_frame_serializer: directed self-checking bench for fft_frame_serializer (N = 8).
// Honours FFT_SER_BITREV_EN for the expected sample order.

module tb_fft_frame_serializer;
    import fft_pkg::*;

    localparam int N      = 8;
    localparam int IDX_W  = 3;
    localparam int WORD_W = 1 + IDX_W + 1 + 1 + 32;

    logic                     clk;
    logic                     reset;
    complex_product_t [N-1:0] fft_in;
    logic                     in_valid;
    logic                     in_mode;
    complex_product_t         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic                     out_mode;
    logic                     overflow;
    logic                     ovf_clear;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] obs;
    logic [WORD_W-1:0] expw;

    // Hand-computed 3-bit reversal of 0..7.
    int bitrev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_frame_serializer #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .fft_in    (fft_in),
        .in_valid  (in_valid),
        .in_mode   (in_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_mode  (out_mode),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic complex_product_t [N-1:0] make_frame(input int base);
        complex_product_t [N-1:0] f;
        for (int k = 0; k < N; k++) begin
            f[k].r = 16'(base + k);
            f[k].i = 16'(-(base + k));
        end
        return f;
    endfunction

    // Expected {valid, index, last, mode, data} for sample k of a frame of given base.
    function automatic logic [WORD_W-1:0] exp_word(input bit valid, input int base,
                                                   input int k, input bit mode);
        int s;
        logic [15:0] r;
        logic [15:0] im;
        if (!valid) return '0;
`ifdef FFT_SER_BITREV_EN
        s = bitrev8[k];
`else
        s = k;
`endif
        r  = 16'(base + s);
        im = 16'(-(base + s));
        return {1'b1, IDX_W'(k), (k == N - 1), mode, r, im};
    endfunction

    function automatic logic [WORD_W-1:0] obs_word();
        return {out_valid, out_index, out_last, out_mode, out_data};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        ovf_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        obs = obs_word();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", obs, {WORD_W{1'b0}});
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        fft_in    = make_frame(0);
        in_mode   = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            obs  = obs_word();
            expw = exp_word(1'b1, 0, k, 1'b1);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL single k=%0d got %h want %h", k, obs, expw);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fft_in    = make_frame(0);
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            if (i == 1) begin
                fft_in  = make_frame(100);
                in_mode = 1'b1;
            end
            obs  = (i < N) ? obs_word() : obs_word();
            expw = (i < N) ? exp_word(1'b1, 0, i, 1'b0) : exp_word(1'b1, 100, i - N, 1'b1);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL b2b i=%0d got %h want %h", i, obs, expw);
            end
        end
        @(negedge clk);
        checks++;
        if ({out_valid, overflow} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_end valid/ovf got %b want 00", {out_valid, overflow});
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        fft_in    = make_frame(0);
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        fft_in  = make_frame(100);
        in_mode = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_early got %b want 0", overflow);
        end
        fft_in  = make_frame(200);
        in_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set got %b want 1", overflow);
        end
        obs  = obs_word();
        expw = exp_word(1'b1, 0, 0, 1'b0);
        checks++;
        if (obs !== expw) begin
            errors++;
            $display("[TB] FAIL stall_a0 got %h want %h", obs, expw);
        end
        fft_in    = make_frame(300);
        in_valid  = 1'b1;
        ovf_clear = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        ovf_clear = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set_wins got %b want 1", overflow);
        end
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear got %b want 0", overflow);
        end
        obs = obs_word();
        checks++;
        if (obs !== expw) begin
            errors++;
            $display("[TB] FAIL stall_a0_late got %h want %h", obs, expw);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            obs  = obs_word();
            expw = (i < N) ? exp_word(1'b1, 0, i, 1'b0) : exp_word(1'b1, 100, i - N, 1'b1);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL ovf_drain i=%0d got %h want %h", i, obs, expw);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_drain_end got %b want 0 (frame C leaked)", out_valid);
        end
    endtask

    task automatic test_ready_toggle();
        int k;
        out_ready = 1'b0;
        fft_in    = make_frame(50);
        in_mode   = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < N; cyc++) begin
            obs  = obs_word();
            expw = exp_word(1'b1, 50, k, 1'b1);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL toggle cyc=%0d k=%0d got %h want %h", cyc, k, obs, expw);
            end
            out_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        checks++;
        if (k != N || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL toggle_end delivered %0d valid %b want %0d valid 0", k, out_valid, N);
        end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b1;
        fft_in    = make_frame(0);
        in_mode   = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs  = obs_word();
            expw = exp_word(1'b1, 0, i, 1'b1);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL pre_reset i=%0d got %h want %h", i, obs, expw);
            end
            if (i == 3) reset = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        obs = obs_word();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset got %h want %h", obs, {WORD_W{1'b0}});
        end
        fft_in   = make_frame(30);
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            obs  = obs_word();
            expw = exp_word(1'b1, 30, k, 1'b0);
            checks++;
            if (obs !== expw) begin
                errors++;
                $display("[TB] FAIL after_reset k=%0d got %h want %h", k, obs, expw);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_end got %b want 0 (stale frame)", out_valid);
        end
    endtask

    // Test sequence.
    initial begin
        reset     = 1'b1;
        fft_in    = '0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        test_reset();
        test_single_frame();
        do_reset();
        test_back_to_back();
        do_reset();
        test_overflow();
        test_ready_toggle();
        do_reset();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
